// File: rtl/vproc_cache_arbiter.sv
// Round-robin arbiter putting the scalar core and vector unit on one cache port.
// An in-order owner FIFO routes every cache response back to its issuer.
module vproc_cache_arbiter #(
    parameter int unsigned ADDR_BIT_W      = 32,
    parameter int unsigned BYTE_W          = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  p0_req_i,
    input  logic [ADDR_BIT_W-1:0] p0_addr_i,
    input  logic                  p0_we_i,
    input  logic [BYTE_W-1:0]     p0_be_i,
    input  logic [BYTE_W*8-1:0]   p0_wdata_i,
    output logic                  p0_gnt_o,
    output logic                  p0_rvalid_o,

    input  logic                  p1_req_i,
    input  logic [ADDR_BIT_W-1:0] p1_addr_i,
    input  logic                  p1_we_i,
    input  logic [BYTE_W-1:0]     p1_be_i,
    input  logic [BYTE_W*8-1:0]   p1_wdata_i,
    output logic                  p1_gnt_o,
    output logic                  p1_rvalid_o,

    output logic [BYTE_W*8-1:0]   p_rdata_o,
    output logic                  p_err_o,

    output logic                  cache_req_o,
    output logic [ADDR_BIT_W-1:0] cache_addr_o,
    output logic                  cache_we_o,
    output logic [BYTE_W-1:0]     cache_be_o,
    output logic [BYTE_W*8-1:0]   cache_wdata_o,
    input  logic                  cache_gnt_i,
    input  logic                  cache_rvalid_i,
    input  logic [BYTE_W*8-1:0]   cache_rdata_i,
    input  logic                  cache_err_i,

    output logic                  protocol_err_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW =
        (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    logic                       rr_q;
    logic                       lock_q;
    logic                       lock_id_q;
    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [PW-1:0]              wptr_q;
    logic [PW-1:0]              rptr_q;
    logic [CW-1:0]              cnt_q;
    logic                       protocol_err_q;

    logic sel;
    logic full;
    logic push;
    logic pop;
    logic head;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // A stalled requester keeps the port so its fields stay stable until granted.
    always_comb begin
        sel = 1'b0;
        priority case (1'b1)
            lock_q:                sel = lock_id_q;
            p0_req_i && p1_req_i:  sel = ~rr_q;
            p1_req_i:              sel = 1'b1;
            default:               sel = 1'b0;
        endcase
    end

    // Full uses only registered occupancy: no rvalid-to-req path.
    assign full        = (cnt_q == CNT_MAX);
    assign cache_req_o = (p0_req_i | p1_req_i) & ~full;

    assign cache_addr_o  = sel ? p1_addr_i  : p0_addr_i;
    assign cache_we_o    = sel ? p1_we_i    : p0_we_i;
    assign cache_be_o    = sel ? p1_be_i    : p0_be_i;
    assign cache_wdata_o = sel ? p1_wdata_i : p0_wdata_i;

    assign push     = cache_req_o & cache_gnt_i;
    assign p0_gnt_o = push & ~sel;
    assign p1_gnt_o = push &  sel;

    assign pop         = cache_rvalid_i & (cnt_q != '0);
    assign head        = fifo_q[rptr_q];
    assign p0_rvalid_o = pop & ~head;
    assign p1_rvalid_o = pop &  head;

    assign p_rdata_o      = cache_rdata_i;
    assign p_err_o        = cache_err_i;
    assign protocol_err_o = protocol_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q           <= 1'b1;
            lock_q         <= 1'b0;
            lock_id_q      <= 1'b0;
            fifo_q         <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            cnt_q          <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= sel;
                wptr_q         <= ptr_next(wptr_q);
                rr_q           <= sel;
                lock_q         <= 1'b0;
            end else if (cache_req_o) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel;
            end

            if (pop) begin
                rptr_q <= ptr_next(rptr_q);
            end

            if (push && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CW'(1);
            end

            if (cache_rvalid_i && cnt_q == '0) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vproc_cache_arbiter.sv
// Directed vector bench for vproc_cache_arbiter.
// Per-cycle stimulus/expectation table plus a hand-written lock sequence.
module tb_vproc_cache_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        p0_req_i = 1'b0, p1_req_i = 1'b0;
    logic [31:0] p0_addr_i = '0, p1_addr_i = '0;
    logic        p0_we_i = 1'b0, p1_we_i = 1'b0;
    logic [3:0]  p0_be_i = 4'h1, p1_be_i = 4'h2;
    logic [31:0] p0_wdata_i = 32'h0000_AAAA;
    logic [31:0] p1_wdata_i = 32'h0000_BBBB;
    logic        p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o;
    logic [31:0] p_rdata_o;
    logic        p_err_o;
    logic        cache_req_o;
    logic [31:0] cache_addr_o;
    logic        cache_we_o;
    logic [3:0]  cache_be_o;
    logic [31:0] cache_wdata_o;
    logic        cache_gnt_i = 1'b0, cache_rvalid_i = 1'b0;
    logic [31:0] cache_rdata_i = '0;
    logic        cache_err_i = 1'b0;
    logic        protocol_err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    vproc_cache_arbiter #(
        .ADDR_BIT_W(32), .BYTE_W(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i),
        .p0_we_i(p0_we_i), .p0_be_i(p0_be_i),
        .p0_wdata_i(p0_wdata_i), .p0_gnt_o(p0_gnt_o),
        .p0_rvalid_o(p0_rvalid_o),
        .p1_req_i(p1_req_i), .p1_addr_i(p1_addr_i),
        .p1_we_i(p1_we_i), .p1_be_i(p1_be_i),
        .p1_wdata_i(p1_wdata_i), .p1_gnt_o(p1_gnt_o),
        .p1_rvalid_o(p1_rvalid_o),
        .p_rdata_o(p_rdata_o), .p_err_o(p_err_o),
        .cache_req_o(cache_req_o), .cache_addr_o(cache_addr_o),
        .cache_we_o(cache_we_o), .cache_be_o(cache_be_o),
        .cache_wdata_o(cache_wdata_o), .cache_gnt_i(cache_gnt_i),
        .cache_rvalid_i(cache_rvalid_i), .cache_rdata_i(cache_rdata_i),
        .cache_err_i(cache_err_i), .protocol_err_o(protocol_err_o)
    );

    typedef struct {
        logic        rst;
        logic        r0;
        logic [31:0] a0;
        logic        we0;
        logic        r1;
        logic [31:0] a1;
        logic        we1;
        logic        cg;
        logic        rv;
        logic [31:0] rd;
        logic        er;
        logic        g0, g1, v0, v1, creq, esel, perr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic r0, input logic [31:0] a0,
        input logic we0, input logic r1, input logic [31:0] a1,
        input logic we1, input logic cg, input logic rv,
        input logic [31:0] rd, input logic er,
        input logic g0, input logic g1, input logic v0, input logic v1,
        input logic creq, input logic esel, input logic perr);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.a0 = a0; v.we0 = we0;
        v.r1 = r1; v.a1 = a1; v.we1 = we1; v.cg = cg;
        v.rv = rv; v.rd = rd; v.er = er;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
        v.creq = creq; v.esel = esel; v.perr = perr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_i          = v.rst;
        p0_req_i       = v.r0;
        p0_addr_i      = v.a0;
        p0_we_i        = v.we0;
        p1_req_i       = v.r1;
        p1_addr_i      = v.a1;
        p1_we_i        = v.we1;
        cache_gnt_i    = v.cg;
        cache_rvalid_i = v.rv;
        cache_rdata_i  = v.rd;
        cache_err_i    = v.er;
    endtask

    task automatic idle();
        drive(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    endtask

    initial begin
        vec_t v;
        logic [31:0] ea;
        logic [36:0] ef;
        logic        ew;
        bit          seen;

        // reset state: combinational outputs with cnt=0
        vecs.push_back(mk(1,1,32'h40,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        // single read
        vecs.push_back(mk(0,1,32'h100,0,0,0,0,1,0,0,0, 1,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'hDEADBEEF,0,
                          0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        // round robin, p0 first after reset
        vecs.push_back(mk(0,1,32'h10,0,1,32'h20,1,1,0,0,0,
                          1,0,0,0,1,0,0));
        vecs.push_back(mk(0,1,32'h10,0,1,32'h20,1,1,1,32'hA1,0,
                          0,1,1,0,1,1,0));
        vecs.push_back(mk(0,1,32'h10,0,1,32'h20,1,1,1,32'hA2,0,
                          1,0,0,1,1,0,0));
        vecs.push_back(mk(0,1,32'h10,0,1,32'h20,1,1,1,32'hA3,0,
                          0,1,1,0,1,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'hA4,0, 0,0,0,1,0,0,0));
        // lock: p1 stalled, p0 joins, address stays p1's
        vecs.push_back(mk(0,0,0,0,1,32'h200,0,0,0,0,0,
                          0,0,0,0,1,1,0));
        vecs.push_back(mk(0,1,32'h300,0,1,32'h200,0,0,0,0,0,
                          0,0,0,0,1,1,0));
        vecs.push_back(mk(0,1,32'h300,0,1,32'h200,0,0,0,0,0,
                          0,0,0,0,1,1,0));
        vecs.push_back(mk(0,1,32'h300,0,1,32'h200,0,1,0,0,0,
                          0,1,0,0,1,1,0));
        vecs.push_back(mk(0,1,32'h300,0,0,0,0,1,1,32'hB0,0,
                          1,0,0,1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'hB1,0, 0,0,1,0,0,0,0));
        // full
        vecs.push_back(mk(0,1,32'h400,0,0,0,0,1,0,0,0, 1,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,32'h500,0,1,0,0,0, 0,1,0,0,1,1,0));
        vecs.push_back(mk(0,1,32'h600,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,32'h600,0,0,0,0,1,1,32'hC0,0,
                          0,0,1,0,0,0,0));
        vecs.push_back(mk(0,1,32'h600,0,0,0,0,1,0,0,0, 1,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'hC1,0, 0,0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'hC2,0, 0,0,1,0,0,0,0));
        // routing with delayed responses
        vecs.push_back(mk(0,1,32'h700,1,0,0,0,1,0,0,0, 1,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,32'h704,0,1,0,0,0, 0,1,0,0,1,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'hAAAA0001,0,
                          0,0,1,0,0,0,0));
        vecs.push_back(mk(0,1,32'h708,0,0,0,0,1,0,0,0, 1,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'hBBBB0002,0,
                          0,0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'hCCCC0003,0,
                          0,0,1,0,0,0,0));
        // protocol error, then reset mid-transaction
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'hBAD,1, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1));
        vecs.push_back(mk(0,1,32'h800,0,0,0,0,1,0,0,0, 1,0,0,0,1,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,32'h55,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));

        repeat (2) @(negedge clk_i);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v);
            #2;
            ea = v.esel ? v.a1 : v.a0;
            ew = v.esel ? v.we1 : v.we0;
            ef = v.esel ? {4'h2, 32'h0000_BBBB, ew}
                        : {4'h1, 32'h0000_AAAA, ew};
            chk($sformatf("v%0d.ctl", i),
                64'({p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o,
                     cache_req_o, protocol_err_o}),
                64'({v.g0, v.g1, v.v0, v.v1, v.creq, v.perr}));
            chk($sformatf("v%0d.addr", i), 64'(cache_addr_o), 64'(ea));
            chk($sformatf("v%0d.fwd", i),
                64'({cache_be_o, cache_wdata_o, cache_we_o}), 64'(ef));
            chk($sformatf("v%0d.rsp", i),
                64'({p_err_o, p_rdata_o}), 64'({v.er, v.rd}));
            @(negedge clk_i);
        end

        // lock hold: p0 stalls 3 cycles while p1 also requests
        rst_i = 1'b0;
        p0_req_i = 1'b1; p0_addr_i = 32'h900;
        p1_req_i = 1'b1; p1_addr_i = 32'hA00;
        cache_gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("hold%0d.addr", k),
                64'(cache_addr_o), 64'h900);
            @(negedge clk_i);
        end
        cache_gnt_i = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            #2;
            if (p0_gnt_o) seen = 1'b1;
            else @(negedge clk_i);
        end
        chk("hold.p0_gnt", 64'(seen), 64'd1);
        @(negedge clk_i);
        #2;
        chk("hold.next_p1",
            64'({p0_gnt_o, p1_gnt_o, cache_addr_o}),
            64'({1'b0, 1'b1, 32'hA00}));
        @(negedge clk_i);
        idle();
        cache_rvalid_i = 1'b1; cache_rdata_i = 32'h1111;
        #2;
        chk("hold.rsp0", 64'({p0_rvalid_o, p1_rvalid_o}), 64'b10);
        @(negedge clk_i);
        cache_rvalid_i = 1'b1; cache_rdata_i = 32'h2222;
        #2;
        chk("hold.rsp1", 64'({p0_rvalid_o, p1_rvalid_o}), 64'b01);
        @(negedge clk_i);
        idle();
        #2;
        chk("hold.perr", 64'(protocol_err_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vproc_cache_arbiter.md
# vproc_cache_arbiter

Two-requester arbiter sharing the single CPU-side request port of the vector-processor data cache. It multiplexes the scalar-core and vector-unit memory interfaces onto the cache in round-robin order. A requester is held on the cache port until it is granted. The arbiter tracks the owner of every outstanding transaction in an in-order ID FIFO, so it can route each cache response back to the requester that issued it.

## Interface
- ADDR_BIT_W, 32, address width (bits)
- BYTE_W, 4, data width (bytes); must equal the cache's CPU data width
- MAX_OUTSTANDING, 2, maximum number of granted-but-unanswered transactions (≥1)

All ports below. Clocking and reset: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- p0_req_i / p1_req_i  in  1  requester 0 / 1 request
- p0_addr_i / p1_addr_i  in  ADDR_BIT_W  request address
- p0_we_i / p1_we_i  in  1  write enable
- p0_be_i / p1_be_i  in  BYTE_W  byte enable
- p0_wdata_i / p1_wdata_i  in  BYTE_W*8  write data
- p0_gnt_o / p1_gnt_o  out  1  request accepted
- p0_rvalid_o / p1_rvalid_o  out  1  response valid for that requester
- p_rdata_o  out  BYTE_W*8  response data, shared by both requesters
- p_err_o  out  1  response error, shared by both requesters
- cache_req_o  out  1  request to cache
- cache_addr_o  out  ADDR_BIT_W  forwarded address
- cache_we_o  out  1  forwarded write enable
- cache_be_o  out  BYTE_W  forwarded byte enable
- cache_wdata_o  out  BYTE_W*8  forwarded write data
- cache_gnt_i  in  1  cache grant
- cache_rvalid_i  in  1  cache response valid; exactly one per granted request, reads and writes alike, in order
- cache_rdata_i  in  BYTE_W*8  cache response data
- cache_err_i  in  1  cache response error
- protocol_err_o  out  1  sticky flag: cache_rvalid_i seen with no outstanding transaction

## Operation

**State**
- rr_q: last-granted requester, 1 bit.
- lock_q / lock_id_q: request pending on the cache without a grant, and which requester holds the port.
- ID FIFO: MAX_OUTSTANDING entries of 1 bit, with read/write pointers that wrap modulo MAX_OUTSTANDING.
- cnt_q: occupancy, width $clog2(MAX_OUTSTANDING+1).
- protocol_err_q.

**Selection**
- If lock_q is set, the selected requester is lock_id_q.
- Otherwise, if only one requester asserts req, that requester is selected.
- Otherwise, if both assert req, the requester ≠ rr_q is selected.

**Request forwarding**
- cache_req_o = (p0_req_i | p1_req_i) & (cnt_q != MAX_OUTSTANDING).
- cache_addr/we/be/wdata are muxed from the selected requester. When idle they show requester 0's inputs.
- The full check uses only the registered cnt_q. A pop in the same cycle does not unblock the port (no combinational path rvalid→req).

**Grant**
- psel_gnt_o = cache_req_o & cache_gnt_i.
- The non-selected requester's gnt is 0.
- On grant: push the selected ID, set rr_q to the selected ID, clear lock_q.

**Lock**
- If cache_req_o=1 and cache_gnt_i=0: set lock_q and set lock_id_q to the selected ID.
- While locked, cache_addr_o and the other forwarded fields stay sourced from the locked requester, even if the other requester raises req.
- The locked requester must keep req asserted until granted (requester obligation).

**Response**
- When cache_rvalid_i=1 and cnt_q>0: pop the FIFO. p<head>_rvalid_o=1 and the other rvalid=0.
- p_rdata_o and p_err_o are direct copies of cache_rdata_i and cache_err_i.
- Simultaneous push and pop: cnt_q is unchanged and both pointers advance.
- When cache_rvalid_i=1 and cnt_q=0: no pop, both p*_rvalid_o=0, protocol_err_q is set. It stays set until reset.

**Reset**
- Any reset, including one mid-transaction, clears cnt_q, both pointers, lock_q and protocol_err_q, and sets rr_q=1 so requester 0 wins the first contention.
- In-flight responses are discarded. The cache must be reset together with the arbiter.
- Output reset values: all gnt, rvalid and cache_req_o follow their combinational equations with cnt_q=0. protocol_err_o=0.

## Timing
- Zero added latency, all combinational:
  - p*_req_i → cache_req_o
  - cache_gnt_i → p*_gnt_o
  - cache_rvalid_i → p*_rvalid_o
  - cache_rdata_i/err → p_rdata_o/p_err_o
- All state updates on posedge clk_i.
- On a cache hit, a response arrives the cycle after the grant. That response is routed in the cycle it arrives.
- Throughput: one grant per cycle while cnt_q < MAX_OUTSTANDING.

## Test plan
1. **Single read.** Reset, then p0 reads 0x100; cache gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF → p0_gnt_o=1 in the grant cycle; next cycle p0_rvalid_o=1, p_rdata_o=0xDEADBEEF, p1_rvalid_o=0.
2. **Round-robin.** Both requesters hold req; cache gnt=1 and rvalid one cycle later every cycle → grant order p0,p1,p0,p1; responses routed in the same order.
3. **Lock.** p1 requests 0x200; cache gnt=0 for 3 cycles; p0 raises req in cycle 2 → cache_addr_o stays 0x200 until the grant, which goes to p1; the next grant goes to p0.
4. **Full.** MAX_OUTSTANDING=2, two grants with no rvalid → cache_req_o=0 and no gnt despite pending req. rvalid arrives → cache_req_o=1 the following cycle.
5. **Response routing.** Grants p0 (write), p1 (read), p0 (read) with delayed rvalids carrying data A, B, C → p0 gets A, p1 gets B, p0 gets C.
6. **Protocol error and reset.**
   - rvalid with the FIFO empty → protocol_err_o=1 from the next cycle, no p*_rvalid_o.
   - Asserting rst_i mid-transaction clears protocol_err_o and cnt_q.
